// File: rtl/ahblsram_mem_bank_pkg.sv
// Shared constants, FSM state type and width helper for the LSRAM memory bank.
package ahblsram_mem_bank_pkg;

  localparam int AHB_DWIDTH = 32;
  localparam int NUM_LANES  = 4;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

  // Smallest bit count that can address 'value' words (at least 1).
  function automatic int ceil_log2(input int value);
    int n;
    n = 1;
    while ((1 << n) < value) n++;
    return n;
  endfunction

endpackage

// File: rtl/ahblsram_mem_bank_if.sv
// Word-access port between the AHB-Lite front end (master) and the memory bank (slave).
interface ahblsram_mem_bank_if
  import ahblsram_mem_bank_pkg::*;
#(
  parameter int AWIDTH = 16
);

  logic                  mem_ren;
  logic                  mem_wen;
  logic [AWIDTH-1:0]     mem_addr;
  logic [NUM_LANES-1:0]  mem_byteen;
  logic [AHB_DWIDTH-1:0] mem_wdata;
  logic [AHB_DWIDTH-1:0] mem_rdata;
  logic                  init_done;
  logic                  mem_busy;
  logic                  err_oob;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata,
    input  mem_rdata, init_done, mem_busy, err_oob
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata,
    output mem_rdata, init_done, mem_busy, err_oob
  );

endinterface

// File: rtl/ahblsram_mem_bank_array.sv
// Single-port, byte-enabled, read-first synchronous RAM shaped for fabric LSRAM.
module ahblsram_mem_array
  import ahblsram_mem_bank_pkg::*;
#(
  parameter int DEPTH  = 65536,
  parameter int AWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [AWIDTH-1:0]     i_addr,
  input  logic [NUM_LANES-1:0]  i_be,
  input  logic [AHB_DWIDTH-1:0] i_wdata,
  output logic [AHB_DWIDTH-1:0] o_rdata
);

  logic [NUM_LANES-1:0][7:0] r_mem [DEPTH];
  logic [AHB_DWIDTH-1:0]     r_rdata;

  // Byte-lane writes and registered read; the read sees the pre-write word.
  // NOTE: the array and its read register carry no reset -- a reset term would stop
  // the tools mapping this onto block RAM; contents come from the fill or from writes.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int n = 0; n < NUM_LANES; n++) begin
        if (i_be[n]) r_mem[i_addr][n] <= i_wdata[8*n +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahblsram_mem_bank.sv
// LSRAM memory bank: post-reset fill sequencer, out-of-range checking and
// optional output register around a byte-enabled single-port array.
module ahblsram_mem_bank
  import ahblsram_mem_bank_pkg::*;
#(
  parameter int                    MEM_DEPTH   = 65536,
  parameter int                    PIPE        = 1,
  parameter int                    INIT_ENABLE = 1,
  parameter logic [AHB_DWIDTH-1:0] INIT_VALUE  = 32'h0000_0000
) (
  input logic                HCLK,
  input logic                HRESET,
  ahblsram_mem_bank_if.slave bus
);

  localparam int                    MEM_AWIDTH  = ceil_log2(MEM_DEPTH);
  localparam state_t                RESET_STATE = (INIT_ENABLE != 0) ? FILL : READY;
  localparam logic [MEM_AWIDTH-1:0] LAST_ADDR   = MEM_AWIDTH'(MEM_DEPTH - 1);
  localparam logic [MEM_AWIDTH:0]   DEPTH_EXT   = (MEM_AWIDTH + 1)'(MEM_DEPTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [MEM_AWIDTH-1:0] r_fill_cnt;

  logic                  w_acc_en;
  logic                  w_oob;
  logic                  w_rd_req;
  logic                  w_wr_req;

  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [MEM_AWIDTH-1:0] w_ram_addr;
  logic [NUM_LANES-1:0]  w_ram_be;
  logic [AHB_DWIDTH-1:0] w_ram_wdata;
  logic [AHB_DWIDTH-1:0] w_ram_rdata;

  logic                  r_rd_vld;
  logic                  r_rd_oob;
  logic                  r_err_oob;
  logic [AHB_DWIDTH-1:0] r_rd_last;
  logic [AHB_DWIDTH-1:0] w_rd_data;

  // User accesses count only in READY and outside reset; the range check
  // widens the address by one bit so MEM_DEPTH itself is representable.
  assign w_acc_en = (r_state == READY) && !HRESET;
  assign w_oob    = {1'b0, bus.mem_addr} >= DEPTH_EXT;
  assign w_rd_req = w_acc_en && bus.mem_ren;
  assign w_wr_req = w_acc_en && bus.mem_wen;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= RESET_STATE;
    else        r_state <= w_state_nxt;
  end

  // Next state and array port steering: the fill sequencer owns the port in FILL.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = bus.mem_addr;
    w_ram_be    = bus.mem_byteen;
    w_ram_wdata = bus.mem_wdata;
    case (r_state)
      FILL: begin
        w_ram_we    = !HRESET;
        w_ram_addr  = r_fill_cnt;
        w_ram_be    = '1;
        w_ram_wdata = INIT_VALUE;
        if (r_fill_cnt == LAST_ADDR) w_state_nxt = READY;
      end
      READY: begin
        w_ram_we = w_wr_req && !w_oob;
        w_ram_re = w_rd_req && !w_oob;
      end
      default: w_state_nxt = RESET_STATE;
    endcase
  end

  // Fill address counter, one location per cycle while filling.
  always_ff @(posedge HCLK) begin
    if (HRESET)                r_fill_cnt <= '0;
    else if (r_state == FILL)  r_fill_cnt <= r_fill_cnt + 1'b1;
  end

  // Read-valid pipeline and the out-of-range error pulse.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rd_vld  <= 1'b0;
      r_rd_oob  <= 1'b0;
      r_err_oob <= 1'b0;
    end else begin
      r_rd_vld  <= w_rd_req;
      r_rd_oob  <= w_rd_req && w_oob;
      r_err_oob <= (w_rd_req || w_wr_req) && w_oob;
    end
  end

  ahblsram_mem_array #(
    .DEPTH  (MEM_DEPTH),
    .AWIDTH (MEM_AWIDTH)
  ) u_array (
    .clk     (HCLK),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign w_rd_data = r_rd_oob ? '0 : w_ram_rdata;

  // Last completed read: the PIPE=1 output register, and the hold value for PIPE=0.
  always_ff @(posedge HCLK) begin
    if (HRESET)        r_rd_last <= '0;
    else if (r_rd_vld) r_rd_last <= w_rd_data;
  end

  assign bus.mem_rdata = (PIPE == 0 && r_rd_vld) ? w_rd_data : r_rd_last;
  assign bus.mem_busy  = (r_state == FILL);
  assign bus.init_done = (r_state == READY);
  assign bus.err_oob   = r_err_oob;

endmodule

// File: tb/tb_ahblsram_mem_bank.sv
// Directed bench for ahblsram_mem_bank: three instances (depth 16 / PIPE=1,
// depth 12 / PIPE=0, no-fill), read results checked through per-instance scoreboards.
module tb_ahblsram_mem_bank;
  import ahblsram_mem_bank_pkg::*;

  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst;
  logic [1:0]      ren;
  logic [1:0]      wen;
  logic [AW-1:0]   addr  [2];
  logic [3:0]      be    [2];
  logic [31:0]     wdata [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  ahblsram_mem_bank_if #(.AWIDTH(AW)) if_a ();
  ahblsram_mem_bank_if #(.AWIDTH(AW)) if_b ();
  ahblsram_mem_bank_if #(.AWIDTH(AW)) if_c ();

  assign if_a.mem_ren    = ren[0];
  assign if_a.mem_wen    = wen[0];
  assign if_a.mem_addr   = addr[0];
  assign if_a.mem_byteen = be[0];
  assign if_a.mem_wdata  = wdata[0];

  assign if_b.mem_ren    = ren[1];
  assign if_b.mem_wen    = wen[1];
  assign if_b.mem_addr   = addr[1];
  assign if_b.mem_byteen = be[1];
  assign if_b.mem_wdata  = wdata[1];

  assign if_c.mem_ren    = 1'b0;
  assign if_c.mem_wen    = 1'b0;
  assign if_c.mem_addr   = '0;
  assign if_c.mem_byteen = '0;
  assign if_c.mem_wdata  = '0;

  ahblsram_mem_bank #(
    .MEM_DEPTH(16), .PIPE(1), .INIT_ENABLE(1), .INIT_VALUE(32'hA5A5_A5A5)
  ) u_a (.HCLK(clk), .HRESET(rst[0]), .bus(if_a.slave));

  ahblsram_mem_bank #(
    .MEM_DEPTH(12), .PIPE(0), .INIT_ENABLE(1), .INIT_VALUE(32'hC0DE_0000)
  ) u_b (.HCLK(clk), .HRESET(rst[1]), .bus(if_b.slave));

  ahblsram_mem_bank #(
    .MEM_DEPTH(16), .PIPE(0), .INIT_ENABLE(0), .INIT_VALUE(32'h0)
  ) u_c (.HCLK(clk), .HRESET(rst[2]), .bus(if_c.slave));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] da(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] db(input int i);
    return 32'h2000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  function automatic logic busy(input int k);
    return (k == 0) ? if_a.mem_busy : if_b.mem_busy;
  endfunction

  // Drive one access for a cycle; a read queues its expected word at the
  // cycle it must appear (latency 2 for instance A, 1 for instance B).
  task automatic access(input int k, input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp);
    exp_t e;
    ren[k] = r; wen[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    if (r) begin
      e.data = exp;
      e.due  = cyc + ((k == 0) ? 2 : 1);
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    tick();
    ren[k] = 1'b0; wen[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    access(k, 1'b0, 1'b1, a, d, b, 32'h0);
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a, input logic [31:0] exp);
    access(k, 1'b1, 1'b0, a, 32'h0, 4'h0, exp);
  endtask

  task automatic count_fill(input int k, input int expected, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy(k) && n < 64);
    check(tag, 32'(n), 32'(expected));
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (sb0.size() > 0 && sb0[0].due == cyc) begin
      check($sformatf("a_rdata@%0d", cyc), if_a.mem_rdata, sb0[0].data);
      void'(sb0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (sb1.size() > 0 && sb1[0].due == cyc) begin
      check($sformatf("b_rdata@%0d", cyc), if_b.mem_rdata, sb1[0].data);
      void'(sb1.pop_front());
    end
  end

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 3'b111;
    ren = '0;
    wen = '0;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; be[k] = '0; wdata[k] = '0;
    end
    repeat (3) tick();

    // Reset state
    check("a_busy_rst",  32'(if_a.mem_busy),  32'd1);
    check("a_done_rst",  32'(if_a.init_done), 32'd0);
    check("a_rdata_rst", if_a.mem_rdata,      32'h0);
    check("a_err_rst",   32'(if_a.err_oob),   32'd0);
    check("c_done_rst",  32'(if_c.init_done), 32'd1);
    check("c_busy_rst",  32'(if_c.mem_busy),  32'd0);

    // Fill on A interrupted by reset at fill cycle 7, then a full restart
    rst[0] = 1'b0;
    repeat (7) tick();
    rst[0] = 1'b1;
    tick();
    check("a_busy_midrst", 32'(if_a.mem_busy), 32'd1);
    tick();
    rst[0] = 1'b0;
    count_fill(0, 16, "a_fill_cycles");
    check("a_done_filled", 32'(if_a.init_done), 32'd1);

    // No-fill instance is ready straight out of reset
    rst[2] = 1'b0;
    tick();
    check("c_done", 32'(if_c.init_done), 32'd1);
    check("c_busy", 32'(if_c.mem_busy),  32'd0);
    check("c_rdata", if_c.mem_rdata,     32'h0);

    // Fill on B (depth 12)
    rst[1] = 1'b0;
    count_fill(1, 12, "b_fill_cycles");

    // A: every location holds the fill word
    for (int i = 0; i < 16; i++) rd(0, AW'(i), 32'hA5A5_A5A5);

    // A: byte enables, then an all-lanes-off write
    wr(0, 4'd3, 32'h1122_3344, 4'hF);
    wr(0, 4'd3, 32'hFFFF_FFFF, 4'b0101);
    rd(0, 4'd3, 32'h11FF_33FF);
    wr(0, 4'd3, 32'h0000_0000, 4'b0000);
    rd(0, 4'd3, 32'h11FF_33FF);

    // A: read-first on a simultaneous read/write
    wr(0, 4'd5, 32'h0000_0000, 4'hF);
    access(0, 1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000);
    rd(0, 4'd5, 32'hDEAD_BEEF);

    // A: back-to-back stream, latency 2
    for (int i = 0; i < 8; i++) wr(0, AW'(i), da(i), 4'hF);
    for (int i = 0; i < 8; i++) rd(0, AW'(i), da(i));

    // B: preload, then out-of-range write and read
    for (int i = 0; i < 8; i++) wr(1, AW'(i), db(i), 4'hF);
    check("b_err_inrange", 32'(if_b.err_oob), 32'd0);
    rd(1, 4'd0, db(0));
    wr(1, 4'd13, 32'hBAD0_BAD0, 4'hF);
    check("b_err_oob_wr", 32'(if_b.err_oob), 32'd1);
    rd(1, 4'd13, 32'h0);
    check("b_err_oob_rd", 32'(if_b.err_oob), 32'd1);
    tick();
    check("b_err_idle", 32'(if_b.err_oob), 32'd0);

    // B: stream all valid addresses, latency 1; locations 8..11 keep the fill word
    for (int i = 0; i < 12; i++) rd(1, AW'(i), (i < 8) ? db(i) : 32'hC0DE_0000);
    repeat (3) tick();
    check("b_rdata_hold", if_b.mem_rdata, 32'hC0DE_0000);
    check("a_rdata_hold", if_a.mem_rdata, da(7));

    check("a_sb_drained", 32'(sb0.size()), 32'd0);
    check("b_sb_drained", 32'(sb1.size()), 32'd0);

    // A: reset with a read in flight; nothing stale may appear
    ren[0] = 1'b1; addr[0] = 4'd6;
    tick();
    ren[0] = 1'b0;
    rst[0] = 1'b1;
    tick();
    check("a_rdata_rst_inflight", if_a.mem_rdata, 32'h0);
    rst[0] = 1'b0;
    tick();
    check("a_rdata_after_rst", if_a.mem_rdata, 32'h0);
    check("a_busy_refill", 32'(if_a.mem_busy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
